// File: rtl/ebi_snoop_arbiter.sv
// ebi_snoop_arbiter: shares the EBI master's single snoop request/response port among NUM_REQ snoop
// sources. Round-robin grant, one snoop in flight at a time. The grant is held from the request
// handshake through the last response beat, so responses always route back to the issuing source.
// Handshake rule on every channel: a transfer happens in a cycle where valid and ready are both high.
// The sender holds valid and payload stable until that cycle. No ready output depends combinationally
// on the valid of the same channel.
module ebi_snoop_arbiter #(
    parameter int NUM_REQ          = 2,
    parameter int PADDR_WIDTH      = 32,
    parameter int DATA_WIDTH       = 64,
    parameter int CACHELINE_LENGTH = 512
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_snvalid_i,
    output logic [NUM_REQ-1:0]             req_snready_o,
    input  logic [NUM_REQ*PADDR_WIDTH-1:0] req_addr_i,
    input  logic [NUM_REQ*4-1:0]           req_snoop_i,
    output logic [NUM_REQ-1:0]             rsp_snvalid_o,
    input  logic [NUM_REQ-1:0]             rsp_snready_i,
    output logic                           rsp_has_data_o,
    output logic [DATA_WIDTH-1:0]          rsp_dat_o,
    output logic                           rsp_ack_o,
    output logic                           ebi_snvalid_o,
    input  logic                           ebi_snready_i,
    output logic [PADDR_WIDTH-1:0]         ebi_sn_addr_o,
    output logic [3:0]                     ebi_sn_snoop_o,
    input  logic                           ebi_rsp_snvalid_i,
    output logic                           ebi_rsp_snready_o,
    input  logic                           ebi_rsp_has_data_i,
    input  logic [DATA_WIDTH-1:0]          ebi_rsp_dat_i,
    input  logic                           ebi_ack_i,
    output logic                           busy_o,
    output logic [$clog2(NUM_REQ)-1:0]     owner_o
);

    localparam int BEATS = CACHELINE_LENGTH / DATA_WIDTH;
    localparam int OW    = $clog2(NUM_REQ);
    localparam int CW    = $clog2(BEATS) + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [OW-1:0] owner_q, owner_d;
    logic [OW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CW-1:0] beat_cnt_q, beat_cnt_d;

    logic [OW-1:0] cand;
    logic [OW-1:0] pick_idx;
    logic          pick_found;
    logic          rsp_beat;
    logic          rsp_last;

    // Round-robin search: first valid requester starting at rr_ptr and wrapping modulo NUM_REQ.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = rr_ptr_q;
        cand       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = OW'((int'(rr_ptr_q) + i) % NUM_REQ);
            if (!pick_found && req_snvalid_i[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // A beat is a response handshake with the owner. A beat is the last one if it is dataless or it is the final line beat.
    always_comb begin
        rsp_beat = (state_q == ST_RESP) && ebi_rsp_snvalid_i && rsp_snready_i[owner_q];
        rsp_last = !ebi_rsp_has_data_i || (beat_cnt_q == CW'(BEATS - 1));
    end

    // State register: synchronous active-high reset drops any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Next state: arbitrate in IDLE, issue the request, then count response beats until done.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    owner_d = pick_idx;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // A withdrawn request releases the grant without moving priority.
                if (!req_snvalid_i[owner_q]) begin
                    state_d = ST_IDLE;
                end else if (ebi_snready_i) begin
                    state_d    = ST_RESP;
                    beat_cnt_d = '0;
                end
            end
            ST_RESP: begin
                if (rsp_beat) begin
                    if (rsp_last) begin
                        state_d    = ST_IDLE;
                        beat_cnt_d = '0;
                        rr_ptr_d   = (owner_q == OW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: route the owner's request to the EBI and route the EBI response back to the owner; all quiet in IDLE.
    always_comb begin
        req_snready_o     = '0;
        rsp_snvalid_o     = '0;
        rsp_has_data_o    = 1'b0;
        rsp_dat_o         = '0;
        rsp_ack_o         = 1'b0;
        ebi_snvalid_o     = 1'b0;
        ebi_sn_addr_o     = '0;
        ebi_sn_snoop_o    = '0;
        ebi_rsp_snready_o = 1'b0;
        case (state_q)
            ST_ISSUE: begin
                ebi_snvalid_o          = req_snvalid_i[owner_q];
                ebi_sn_addr_o          = req_addr_i[int'(owner_q)*PADDR_WIDTH +: PADDR_WIDTH];
                ebi_sn_snoop_o         = req_snoop_i[int'(owner_q)*4 +: 4];
                req_snready_o[owner_q] = ebi_snready_i;
            end
            ST_RESP: begin
                rsp_snvalid_o[owner_q] = ebi_rsp_snvalid_i;
                ebi_rsp_snready_o      = rsp_snready_i[owner_q];
                rsp_has_data_o         = ebi_rsp_has_data_i;
                rsp_dat_o              = ebi_rsp_dat_i;
                rsp_ack_o              = ebi_ack_i;
            end
            default: ;
        endcase
    end

    assign busy_o  = (state_q != ST_IDLE);
    assign owner_o = owner_q;

endmodule

// File: tb/tb_ebi_snoop_arbiter.sv
// tb_ebi_snoop_arbiter: three-requester bench for ebi_snoop_arbiter with directed vectors, multi-cycle
// corner sequences and a randomized run against a transaction-level reference model.
module tb_ebi_snoop_arbiter;

    localparam int N     = 3;
    localparam int AW    = 32;
    localparam int DW    = 64;
    localparam int CL    = 512;
    localparam int BEATS = CL / DW;
    localparam int OW    = $clog2(N);

    // ---------------- clock / reset / DUT ----------------
    logic            clk;
    logic            rst;
    logic [N-1:0]    snv;
    logic [N-1:0]    sn_rdy;
    logic [N*AW-1:0] addr;
    logic [N*4-1:0]  snp;
    logic [N-1:0]    rsp_v;
    logic [N-1:0]    rrdy;
    logic            has_data;
    logic [DW-1:0]   dat;
    logic            ack;
    logic            ebi_v;
    logic            ebi_rdy;
    logic [AW-1:0]   ebi_addr;
    logic [3:0]      ebi_snp;
    logic            ebi_rv;
    logic            ebi_rrdy;
    logic            ebi_hd;
    logic [DW-1:0]   ebi_dat;
    logic            ebi_ack;
    logic            busy;
    logic [OW-1:0]   owner;

    int n_cmp = 0;
    int n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ebi_snoop_arbiter #(
        .NUM_REQ(N), .PADDR_WIDTH(AW), .DATA_WIDTH(DW), .CACHELINE_LENGTH(CL)
    ) dut (
        .clk(clk), .rst(rst),
        .req_snvalid_i(snv), .req_snready_o(sn_rdy), .req_addr_i(addr), .req_snoop_i(snp),
        .rsp_snvalid_o(rsp_v), .rsp_snready_i(rrdy), .rsp_has_data_o(has_data), .rsp_dat_o(dat),
        .rsp_ack_o(ack),
        .ebi_snvalid_o(ebi_v), .ebi_snready_i(ebi_rdy), .ebi_sn_addr_o(ebi_addr), .ebi_sn_snoop_o(ebi_snp),
        .ebi_rsp_snvalid_i(ebi_rv), .ebi_rsp_snready_o(ebi_rrdy), .ebi_rsp_has_data_i(ebi_hd),
        .ebi_rsp_dat_i(ebi_dat), .ebi_ack_i(ebi_ack),
        .busy_o(busy), .owner_o(owner)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        snv     = '0;
        rrdy    = '0;
        ebi_rdy = 1'b0;
        ebi_rv  = 1'b0;
        ebi_hd  = 1'b0;
        ebi_dat = '0;
        ebi_ack = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_fixed_payload();
        addr = {32'h8000_0240, 32'h8000_0140, 32'h8000_0040};
        snp  = {4'h4, 4'h3, 4'h2};
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [AW-1:0] addr_of(input int i);
        return addr[i*AW +: AW];
    endfunction

    function automatic logic [3:0] snp_of(input int i);
        return snp[i*4 +: 4];
    endfunction

    function automatic int onehot_idx(input logic [N-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    // ---------------- scoreboard ----------------
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] beat_d[BEATS];

    // ---------------- vector table ----------------
    typedef struct {
        logic [N-1:0]  snv;
        logic          erdy;
        logic          rv;
        logic [N-1:0]  rrdy;
        logic          ack;
        logic          x_busy;
        logic [OW-1:0] x_own;
        logic [N-1:0]  x_snrdy;
        logic          x_ebiv;
        logic [N-1:0]  x_rspv;
        logic          x_errdy;
        logic          x_ack;
    } vec_t;

    localparam int NV = 18;
    vec_t tbl[NV];

    // ---------------- reference model state ----------------
    bit m_hold;
    bit m_acc;
    int m_grant;
    int m_left;
    int m_prio;

    initial begin
        int k;
        int toggle;
        int ng;
        int idle;
        int grants[4];
        int gaps[4];
        int exp_order[4];
        bit in_issue;
        bit in_resp;
        logic [N-1:0] e_snrdy;
        logic [N-1:0] e_rspv;

        rst = 1'b1;
        clear_inputs();
        set_fixed_payload();
        do_reset();

        // Reset state.
        #2;
        chk("reset_busy", busy, 1'b0);
        chk("reset_owner", owner, '0);
        chk("reset_ebi_v", ebi_v, 1'b0);
        chk("reset_sn_rdy", sn_rdy, '0);
        chk("reset_rsp_v", rsp_v, '0);

        // snv erdy rv rrdy ack | busy own snrdy ebiv rspv errdy ack
        tbl[0]  = '{3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0};
        tbl[1]  = '{3'b001, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0};
        tbl[2]  = '{3'b001, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 2'd0, 3'b000, 1'b1, 3'b000, 1'b0, 1'b0};
        tbl[3]  = '{3'b001, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 2'd0, 3'b001, 1'b1, 3'b000, 1'b0, 1'b0};
        tbl[4]  = '{3'b000, 1'b0, 1'b1, 3'b001, 1'b1, 1'b1, 2'd0, 3'b000, 1'b0, 3'b001, 1'b1, 1'b1};
        tbl[5]  = '{3'b000, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 2'd0, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0};
        tbl[6]  = '{3'b011, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0};
        tbl[7]  = '{3'b011, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 2'd1, 3'b000, 1'b1, 3'b000, 1'b0, 1'b0};
        tbl[8]  = '{3'b001, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 2'd1, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0};
        tbl[9]  = '{3'b011, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0};
        tbl[10] = '{3'b011, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 2'd1, 3'b010, 1'b1, 3'b000, 1'b0, 1'b0};
        tbl[11] = '{3'b001, 1'b0, 1'b1, 3'b101, 1'b1, 1'b1, 2'd1, 3'b000, 1'b0, 3'b010, 1'b0, 1'b1};
        tbl[12] = '{3'b000, 1'b0, 1'b0, 3'b010, 1'b0, 1'b1, 2'd1, 3'b000, 1'b0, 3'b000, 1'b1, 1'b0};
        tbl[13] = '{3'b000, 1'b0, 1'b1, 3'b010, 1'b1, 1'b1, 2'd1, 3'b000, 1'b0, 3'b010, 1'b1, 1'b1};
        tbl[14] = '{3'b001, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0};
        tbl[15] = '{3'b001, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 2'd0, 3'b000, 1'b1, 3'b000, 1'b0, 1'b0};
        tbl[16] = '{3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 2'd0, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0};
        tbl[17] = '{3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0};

        for (int v = 0; v < NV; v++) begin
            @(negedge clk);
            snv     = tbl[v].snv;
            ebi_rdy = tbl[v].erdy;
            ebi_rv  = tbl[v].rv;
            rrdy    = tbl[v].rrdy;
            ebi_ack = tbl[v].ack;
            ebi_hd  = 1'b0;
            #2;
            chk($sformatf("v%0d_busy", v), busy, tbl[v].x_busy);
            if (tbl[v].x_busy) chk($sformatf("v%0d_owner", v), owner, tbl[v].x_own);
            chk($sformatf("v%0d_sn_rdy", v), sn_rdy, tbl[v].x_snrdy);
            chk($sformatf("v%0d_ebi_v", v), ebi_v, tbl[v].x_ebiv);
            chk($sformatf("v%0d_rsp_v", v), rsp_v, tbl[v].x_rspv);
            chk($sformatf("v%0d_ebi_rrdy", v), ebi_rrdy, tbl[v].x_errdy);
            chk($sformatf("v%0d_ack", v), ack, tbl[v].x_ack);
            if (tbl[v].x_ebiv) begin
                chk($sformatf("v%0d_addr", v), ebi_addr, addr_of(int'(tbl[v].x_own)));
                chk($sformatf("v%0d_snoop", v), ebi_snp, snp_of(int'(tbl[v].x_own)));
            end
        end

        // 8-beat data response with owner ready toggling; priority currently at 2 so requester 0 wins.
        for (int b = 0; b < BEATS; b++) begin
            beat_d[b] = {$urandom, $urandom};
            exp_q.push_back(beat_d[b]);
        end
        @(negedge clk);
        clear_inputs();
        snv     = 3'b001;
        ebi_rdy = 1'b1;
        #2;
        chk("d_idle_busy", busy, 1'b0);
        @(negedge clk);
        #2;
        chk("d_issue_owner", owner, 2'd0);
        chk("d_issue_sn_rdy", sn_rdy, 3'b001);
        chk("d_issue_addr", ebi_addr, 32'h8000_0040);
        k      = 0;
        toggle = 1;
        for (int c = 0; c < 40 && k < BEATS; c++) begin
            @(negedge clk);
            snv     = '0;
            ebi_rdy = 1'b0;
            ebi_rv  = 1'b1;
            ebi_hd  = 1'b1;
            ebi_dat = beat_d[k];
            rrdy    = (toggle != 0) ? 3'b001 : 3'b110;
            #2;
            chk("d_busy", busy, 1'b1);
            chk("d_rsp_v", rsp_v, 3'b001);
            chk("d_has_data", has_data, 1'b1);
            chk("d_ebi_rrdy", ebi_rrdy, (toggle != 0));
            if (toggle != 0) begin
                chk($sformatf("d_beat%0d", k), dat, exp_q.pop_front());
                k++;
            end
            toggle = (toggle != 0) ? 0 : 1;
        end
        chk("d_beats_delivered", k, BEATS);
        @(negedge clk);
        clear_inputs();
        #2;
        chk("d_done_busy", busy, 1'b0);
        chk("d_queue_empty", exp_q.size(), 0);

        // Reset during beat 4 of a data response from requester 1.
        @(negedge clk);
        snv     = 3'b010;
        ebi_rdy = 1'b1;
        @(negedge clk);
        #2;
        chk("r_issue_owner", owner, 2'd1);
        chk("r_issue_sn_rdy", sn_rdy, 3'b010);
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            snv     = '0;
            ebi_rdy = 1'b0;
            ebi_rv  = 1'b1;
            ebi_hd  = 1'b1;
            rrdy    = 3'b010;
            ebi_dat = {$urandom, $urandom};
            if (b == 3) rst = 1'b1;
            #2;
            chk($sformatf("r_rsp_v%0d", b), rsp_v, 3'b010);
            chk($sformatf("r_dat%0d", b), dat, ebi_dat);
        end
        @(negedge clk);
        rst     = 1'b0;
        snv     = '0;
        ebi_rdy = 1'b1;
        ebi_rv  = 1'b1;
        rrdy    = 3'b111;
        ebi_ack = 1'b1;
        #2;
        chk("r_busy", busy, 1'b0);
        chk("r_owner", owner, 2'd0);
        chk("r_sn_rdy", sn_rdy, '0);
        chk("r_ebi_v", ebi_v, 1'b0);
        chk("r_rsp_v", rsp_v, '0);
        chk("r_ebi_rrdy", ebi_rrdy, 1'b0);
        chk("r_addr", ebi_addr, '0);
        chk("r_snoop", ebi_snp, '0);
        chk("r_dat", dat, '0);
        chk("r_has_data", has_data, 1'b0);
        chk("r_ack", ack, 1'b0);
        @(negedge clk);
        clear_inputs();
        snv = 3'b011;
        @(negedge clk);
        #2;
        chk("r_after_busy", busy, 1'b1);
        chk("r_after_owner", owner, 2'd0);
        @(negedge clk);
        snv = '0;
        @(negedge clk);

        // All requesters valid continuously with single-cycle acks: order 0,1,2,0, one IDLE cycle between grants.
        do_reset();
        snv     = 3'b111;
        ebi_rdy = 1'b1;
        ebi_rv  = 1'b1;
        ebi_ack = 1'b1;
        ebi_hd  = 1'b0;
        rrdy    = 3'b111;
        exp_order = '{0, 1, 2, 0};
        ng   = 0;
        idle = 0;
        for (int c = 0; c < 40 && ng < 4; c++) begin
            @(negedge clk);
            #2;
            if (!busy) begin
                idle++;
            end else if (sn_rdy != '0) begin
                grants[ng] = onehot_idx(sn_rdy);
                gaps[ng]   = idle;
                idle       = 0;
                ng++;
            end
        end
        chk("rr_grant_count", ng, 4);
        for (int g = 0; g < ng; g++) begin
            chk($sformatf("rr_grant%0d", g), grants[g], exp_order[g]);
            if (g > 0) chk($sformatf("rr_gap%0d", g), gaps[g], 1);
        end

        // Randomized run against the transaction-level model.
        do_reset();
        m_hold = 1'b0;
        m_acc  = 1'b0;
        m_grant = 0;
        m_left  = 0;
        m_prio  = 0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) snv[i] = ($urandom_range(0, 99) < 55);
            ebi_rdy = 1'($urandom_range(0, 1));
            ebi_rv  = ($urandom_range(0, 9) < 6);
            rrdy    = N'($urandom);
            if (!(m_hold && m_acc)) ebi_hd = ($urandom_range(0, 9) < 7);
            ebi_ack = 1'($urandom_range(0, 1));
            ebi_dat = {$urandom, $urandom};
            addr    = {$urandom, $urandom, $urandom};
            snp     = 12'($urandom);
            #2;
            in_issue = m_hold && !m_acc;
            in_resp  = m_hold && m_acc;
            e_snrdy  = '0;
            e_rspv   = '0;
            if (in_issue && ebi_rdy) e_snrdy[m_grant] = 1'b1;
            if (in_resp && ebi_rv) e_rspv[m_grant] = 1'b1;
            chk("m_busy", busy, m_hold);
            if (m_hold) chk("m_owner", owner, m_grant);
            chk("m_sn_rdy", sn_rdy, e_snrdy);
            chk("m_ebi_v", ebi_v, in_issue && snv[m_grant]);
            chk("m_addr", ebi_addr, in_issue ? addr_of(m_grant) : '0);
            chk("m_snoop", ebi_snp, in_issue ? snp_of(m_grant) : '0);
            chk("m_rsp_v", rsp_v, e_rspv);
            chk("m_ebi_rrdy", ebi_rrdy, in_resp && rrdy[m_grant]);
            chk("m_dat", dat, in_resp ? ebi_dat : '0);
            chk("m_has_data", has_data, in_resp && ebi_hd);
            chk("m_ack", ack, in_resp && ebi_ack);
            // Advance the model by one cycle.
            if (!m_hold) begin
                for (int off = 0; off < N; off++) begin
                    if (!m_hold && snv[(m_prio + off) % N]) begin
                        m_hold  = 1'b1;
                        m_acc   = 1'b0;
                        m_grant = (m_prio + off) % N;
                    end
                end
            end else if (!m_acc) begin
                if (!snv[m_grant]) begin
                    m_hold = 1'b0;
                end else if (ebi_rdy) begin
                    m_acc  = 1'b1;
                    m_left = BEATS;
                end
            end else if (ebi_rv && rrdy[m_grant]) begin
                if (ebi_hd) m_left = m_left - 1;
                if (!ebi_hd || m_left == 0) begin
                    m_hold = 1'b0;
                    m_acc  = 1'b0;
                    m_prio = (m_grant + 1) % N;
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
